// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a byte-addressed, 32-bit,
// little-endian data memory. Handles byte/half/word accesses, sign/zero
// extension on loads and read-modify-write for sub-word stores.
// Optional build macro MAU_ALIGN_CHECK_EN: when defined, misaligned half
// and word accesses are rejected with err instead of proceeding.
module mem_access_unit #(
   parameter int MEM_BYTES = 64,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_ren,
   output logic              mem_wen,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_WR, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_we;
   logic [1:0]          r_size;
   logic                r_sext;
   logic [31:0]         r_wdata;
   logic                r_err;
   logic [31:0]         r_rdata;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic                r_mem_ren;
   logic                r_mem_wen;

   logic                w_accept;
   logic                w_bad;
   logic [ADDR_W:0]     w_last;
   logic [31:0]         w_load_val;
   logic [31:0]         w_merge;

   // Extend the addressed low byte/half of a fetched word into a load result.
   function automatic logic [31:0] f_extend(input logic [31:0] d,
                                            input logic [1:0]  sz,
                                            input logic        sx);
      logic [31:0] res;
      case (sz)
         2'b00:   res = {{24{sx & d[7]}}, d[7:0]};
         2'b01:   res = {{16{sx & d[15]}}, d[15:0]};
         default: res = d;
      endcase
      return res;
   endfunction

   // Overlay the new low byte/half on the old word; upper bytes are rewritten unchanged.
   function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [1:0]  sz);
      logic [31:0] res;
      case (sz)
         2'b00:   res = {old_w[31:8], new_w[7:0]};
         2'b01:   res = {old_w[31:16], new_w[15:0]};
         default: res = new_w;
      endcase
      return res;
   endfunction

   assign w_accept   = req && (r_state == S_IDLE);
   assign w_last     = {1'b0, addr} + (ADDR_W+1)'(3);
   assign w_load_val = f_extend(mem_rdata, r_size, r_sext);
   assign w_merge    = f_merge(mem_rdata, r_wdata, r_size);

   // Request validity: illegal size or last byte beyond memory (one extra bit so no wrap).
   always_comb begin
      w_bad = (size == 2'b11) || (w_last > (ADDR_W+1)'(MEM_BYTES - 1));
`ifdef MAU_ALIGN_CHECK_EN
      if ((size == 2'b01) && addr[0])
         w_bad = 1'b1;
      if ((size == 2'b10) && (addr[1:0] != 2'b00))
         w_bad = 1'b1;
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic: word stores skip the read, sub-word stores read first.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_bad)
                  w_next = S_DONE;
               else if (we && (size == 2'b10))
                  w_next = S_WR;
               else
                  w_next = S_RD;
            end
         end
         S_RD:    w_next = S_RWAIT;
         S_RWAIT: w_next = r_we ? S_WR : S_DONE;
         S_WR:    w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Request latch, registered memory port and load result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we        <= 1'b0;
         r_size      <= 2'b00;
         r_sext      <= 1'b0;
         r_wdata     <= '0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_ren   <= 1'b0;
         r_mem_wen   <= 1'b0;
      end else begin
         r_mem_ren <= (w_next == S_RD);
         r_mem_wen <= (w_next == S_WR);
         if (w_accept) begin
            r_we    <= we;
            r_size  <= size;
            r_sext  <= sext;
            r_wdata <= wdata;
            r_err   <= w_bad;
            if (!w_bad)
               r_mem_addr <= addr;
            if (!w_bad && we && (size == 2'b10))
               r_mem_wdata <= wdata;
         end
         if (r_state == S_RWAIT) begin
            if (r_we)
               r_mem_wdata <= w_merge;
            else
               r_rdata <= w_load_val;
         end
      end
   end

   assign done      = (r_state == S_DONE);
   assign err       = done && r_err;
   assign busy      = (r_state != S_IDLE);
   assign rdata     = r_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_ren   = r_mem_ren;
   assign mem_wen   = r_mem_wen;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator that sits between the processor datapath and the byte-addressed 32-bit little-endian data memory, and drives that memory's ren/wen/addr/wdata port.
- Accepts one load or store request at a time and handles byte, halfword and word sizes.
- Sign- or zero-extends load data.
- Performs read-modify-write for sub-word stores, because the memory always writes 4 bytes at addr..addr+3.

Parameters:
MEM_BYTES, 64, number of bytes in the target memory; any access with addr+3 > MEM_BYTES-1 is an error.
ADDR_W, 32, width of request and memory addresses.

Ports:
clk  input  1  clock; all state changes on posedge.
reset  input  1  asynchronous, active-low reset (reset==0 resets).
req  input  1  request valid; accepted on a posedge when req==1 and busy==0.
we  input  1  1=store, 0=load.
size  input  2  00=byte, 01=halfword, 10=word, 11=illegal (error).
sext  input  1  loads only: 1=sign-extend, 0=zero-extend.
addr  input  ADDR_W  byte address of the access.
wdata  input  32  store data, right-aligned.
rdata  output  32  load result; held until the next load completes.
done  output  1  one-cycle pulse when the access completes (ok or error).
err  output  1  valid with done; 1=access aborted, memory not touched.
busy  output  1  high from the accept edge until the cycle done is high, inclusive.
mem_addr  output  ADDR_W  to memory addr.
mem_wdata  output  32  to memory wdata.
mem_ren  output  1  to memory ren.
mem_wen  output  1  to memory wen.
mem_rdata  input  32  from memory data; valid from the edge after ren is sampled.

Behaviour:
- Reset (async, reset==0): state=IDLE; rdata=0, done=0, err=0, busy=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0. Reset during any state aborts the access with no done pulse. A write already sampled by memory is not undone.
- Memory outputs come from registered state only. In IDLE/DONE: mem_ren=mem_wen=0 and mem_addr/mem_wdata hold their last value.
- mem_ren and mem_wen are never both 1.
- Accept: at an edge with req&&!busy, latch we/size/sext/addr/wdata and set busy.
- Error check at accept: if size==11 or addr+3 > MEM_BYTES-1 (unsigned, computed ADDR_W+1 wide so no wrap) -> go to DONE with err=1.
- FSM states: IDLE, RD, RWAIT, WR, DONE.
- Load path: IDLE -> RD (mem_ren=1, mem_addr=addr) -> RWAIT (ren=0; capture mem_rdata at the exiting edge) -> DONE.
- Load result:
  - byte: mem_rdata[7:0] extended.
  - half: mem_rdata[15:0] extended.
  - word: mem_rdata as-is.
  - Extension: sign-extend if sext=1, zero-extend otherwise.
  - rdata updates on the RWAIT->DONE edge.
- Word store: IDLE -> WR (mem_wen=1, mem_addr=addr, mem_wdata=wdata) -> DONE.
- Sub-word store: IDLE -> RD -> RWAIT (capture old word) -> WR -> DONE. In WR, mem_wdata = old word with [7:0] (byte) or [15:0] (half) replaced by the low bits of wdata; upper bytes are written back unchanged.
- DONE: done=1 for exactly one cycle, busy=1, then -> IDLE. err=0 on success.
- Stores leave rdata unchanged.
- Latency from accept edge to done high:
  - load: 3 cycles.
  - word store: 2 cycles.
  - sub-word store: 4 cycles.
  - error: 1 cycle.
- req while busy is ignored (not queued). req held high across DONE is accepted on the edge leaving DONE only if busy==0, i.e. earliest the edge after DONE.
- No unaligned restriction by default; addresses are byte-granular.

Optional Feature:
- Macro: MAU_ALIGN_CHECK_EN.
- Defined: half with addr[0]!=0, or word with addr[1:0]!=0, is an error (err=1, 1-cycle path, memory untouched).
- Undefined: misaligned accesses proceed normally using addr as given.

Test Plan:
1. Reset low mid-RWAIT of a load -> all outputs 0 immediately, no done pulse; after release, busy=0 and req accepted on the next edge.
2. Word store addr=8 wdata=0xDEADBEEF, then word load addr=8 -> done 2 and 3 cycles after the respective accepts, rdata=0xDEADBEEF, err=0.
3. Byte load addr=11 with sext=1 after test 2 -> rdata=0xFFFFFFDE; same load with sext=0 -> 0x000000DE.
4. Byte store addr=9 wdata=0x12 after test 2 -> memory sees ren at addr 9, then wen with wdata=0x00DEAD12 (if bytes 12 are 0x00); word load addr=8 -> 0xDEAD12EF; done 4 cycles after accept.
5. Word load addr=61 (MEM_BYTES=64) and size=11 at addr=0 -> done+err 1 cycle after accept, mem_ren/mem_wen never asserted.
6. With MAU_ALIGN_CHECK_EN, half store addr=5 -> err=1, no wen. Without the macro -> normal 4-cycle RMW writing bytes 5–6.
